fetch_sequencer: RTL and testbench

//  Instruction-fetch controller that sequences the synchronous-read InstructionMemory (1-cycle read latency, byte-address pc in).

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_skid_fifo.sv | 58 +++++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_WORDS = 256;
  localparam int          DEFAULT_PC_STEP    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A PC is fetchable when word-aligned and inside the memory; limit is in bytes.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [33:0] limit);
    return (pc[1:0] == 2'b00) && ({2'b00, pc} < limit);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, decode and redirect signals of the fetch sequencer, seen from the sequencer (master).
interface fetch_sequencer_if;
  logic        enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    input  enable, imem_rdata, if_ready, redirect_valid, redirect_pc,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, fault, fault_pc
  );

  modport slave (
    output enable, imem_rdata, if_ready, redirect_valid, redirect_pc,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, fault, fault_pc
  );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, instr} skid FIFO between the memory return path and decode.
module fetch_skid_fifo
  import fetch_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         btn_reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t entries [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = entries[rd_ptr];

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // NOTE: storage is reset too, so the head (if_pc/if_instr) reads zero out of reset.
  // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues reads to a 1-cycle synchronous memory,
// buffers returns in a skid FIFO, handles redirects and traps illegal PCs.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS,
  parameter int          PC_STEP    = DEFAULT_PC_STEP
) (
  input logic               clk,
  input logic               btn_reset,
  fetch_sequencer_if.master bus
);

  localparam logic [33:0] PC_LIMIT = 34'(IMEM_WORDS) << 2;
  localparam logic [31:0] PC_INC   = 32'(PC_STEP);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  inflight_pc;
  logic         inflight_valid;
  logic         fault;
  logic [31:0]  fault_pc;

  fetch_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [1:0]   occupancy;
  logic [2:0]   slots;
  logic         pop;
  logic         push;
  logic         flush;
  logic         redirect_take;
  logic         redirect_bad;
  logic         seq_bad;
  logic         try_issue;
  logic         issue;
  logic         seq_fault;

  // slots = words that will be buffered or in flight after this cycle's pop.
  always_comb begin
    occupancy     = {fifo_full, !fifo_full && !fifo_empty};
    pop           = !fifo_empty && bus.if_ready;
    slots         = {1'b0, occupancy} + {2'b00, inflight_valid} - {2'b00, pop};
    redirect_take = bus.redirect_valid && (state != ST_FAULT);
    redirect_bad  = !pc_legal(bus.redirect_pc, PC_LIMIT);
    seq_bad       = !pc_legal(fetch_pc, PC_LIMIT);
    try_issue     = (state == ST_RUN) && bus.enable && !bus.redirect_valid;
    issue         = try_issue && !seq_bad && (slots < 3'd2);
    // A bad sequential PC traps only once every older word has left, so they all reach decode.
    seq_fault     = try_issue && seq_bad && (slots == 3'd0);
    flush         = redirect_take || seq_fault;
    push          = inflight_valid && !flush;
  end

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      state          <= ST_IDLE;
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      fault          <= 1'b0;
      fault_pc       <= '0;
    end else if (state == ST_FAULT) begin
      inflight_valid <= 1'b0;
    end else if (redirect_take) begin
      fetch_pc       <= bus.redirect_pc;
      inflight_valid <= 1'b0;
      if (redirect_bad) begin
        state    <= ST_FAULT;
        fault    <= 1'b1;
        fault_pc <= bus.redirect_pc;
      end
    end else if (seq_fault) begin
      state          <= ST_FAULT;
      fault          <= 1'b1;
      fault_pc       <= fetch_pc;
      inflight_valid <= 1'b0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_INC;
      end
      if (state == ST_IDLE && bus.enable) begin
        state <= ST_RUN;
      end else if (state == ST_RUN && !bus.enable && !inflight_valid) begin
        state <= ST_IDLE;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk        (clk),
    .btn_reset  (btn_reset),
    .push       (push),
    .push_entry ('{pc: inflight_pc, instr: bus.imem_rdata}),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = !fifo_empty;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;
  assign bus.fault     = fault;
  assign bus.fault_pc  = fault_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: memory model plus an in-order delivery scoreboard driven by random stimulus.
module tb_fetch_sequencer;

  logic clk;
  logic btn_reset;
  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  int          n_checks;
  int          n_fail;

  // Scoreboard: program-order PC expected next at decode and next at the memory port.
  logic [31:0] exp_pc;
  logic [31:0] exp_issue;
  int          n_issued;
  int          n_delivered;
  int          n_total;
  logic [31:0] last_pc;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic        s_fault;
  logic [31:0] s_fault_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_reset();
    exp_pc      = 32'h0;
    exp_issue   = 32'h0;
    n_issued    = 0;
    n_delivered = 0;
  endtask

  // One clock: sample mid-cycle, score the cycle, then model the synchronous memory read.
  task automatic tick();
    @(negedge clk);
    s_req      = bus.imem_req;
    s_addr     = bus.imem_addr;
    s_valid    = bus.if_valid;
    s_pc       = bus.if_pc;
    s_instr    = bus.if_instr;
    s_fault    = bus.fault;
    s_fault_pc = bus.fault_pc;
    if (s_req) begin
      check("issue_pc", s_addr, exp_issue);
      exp_issue += 32'd4;
      n_issued++;
    end
    if (s_valid && bus.if_ready) begin
      check("if_pc", s_pc, exp_pc);
      check("if_instr", s_instr, mem[exp_pc[9:2]]);
      last_pc = s_pc;
      exp_pc += 32'd4;
      n_delivered++;
      n_total++;
    end
    check("credit", ((n_issued - n_delivered) <= 2) ? 32'd1 : 32'd0, 32'd1);
    if (bus.redirect_valid && !s_fault) begin
      exp_pc      = bus.redirect_pc;
      exp_issue   = bus.redirect_pc;
      n_issued    = 0;
      n_delivered = 0;
    end
    @(posedge clk);
    #1;
    bus.imem_rdata = s_req ? mem[s_addr[9:2]] : $urandom();
  endtask

  task automatic idle_inputs();
    bus.enable         = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rdata     = $urandom();
  endtask

  task automatic apply_reset();
    btn_reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    btn_reset = 1'b0;
    sb_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      32'(bus.imem_req), 32'd0);
    check({tag, "_addr"},     bus.imem_addr,     32'h0);
    check({tag, "_valid"},    32'(bus.if_valid), 32'd0);
    check({tag, "_instr"},    bus.if_instr,      32'h0);
    check({tag, "_pc"},       bus.if_pc,         32'h0);
    check({tag, "_fault"},    32'(bus.fault),    32'd0);
    check({tag, "_fault_pc"}, bus.fault_pc,      32'h0);
  endtask

  initial begin
    int   first;
    int   cnt;
    int   n_quiet_req;
    int   n_quiet_valid;
    logic found;

    n_checks = 0;
    n_fail   = 0;
    n_total  = 0;
    last_pc  = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();

    btn_reset = 1'b1;
    idle_inputs();
    sb_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    btn_reset = 1'b0;

    // Start-up latency and sequential addresses.
    bus.enable   = 1'b1;
    bus.if_ready = 1'b1;
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      tick();
      if (s_req) first = i;
    end
    check("first_req_seen", (first >= 0) ? 32'd1 : 32'd0, 32'd1);
    check("first_addr", s_addr, 32'h0);
    tick();
    check("second_addr", s_addr, 32'h4);
    check("valid_not_early", 32'(s_valid), 32'd0);
    tick();
    check("third_addr", s_addr, 32'h8);
    check("first_valid", 32'(s_valid), 32'd1);
    check("first_if_pc", s_pc, 32'h0);
    check("first_if_instr", s_instr, mem[0]);
    cnt = n_total;
    for (int i = 0; i < 10; i++) tick();
    check("throughput", 32'(n_total - cnt), 32'd10);

    // Backpressure: two words held, issue stops, stream resumes without gaps.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("stall_req", 32'(s_req), 32'd0);
    check("stall_buffered", 32'(n_issued - n_delivered), 32'd2);
    check("stall_valid", 32'(s_valid), 32'd1);
    bus.if_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Redirect with a buffered word and a read in flight.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("redir_valid", 32'(s_valid), 32'd0);
    check("redir_addr", s_addr, 32'h40);
    check("redir_req", 32'(s_req), 32'd1);
    cnt = n_total;
    for (int i = 0; i < 6; i++) tick();
    check("redir_resume", (n_total > cnt) ? 32'd1 : 32'd0, 32'd1);

    // Random traffic: ready, enable and redirects all vary.
    cnt = n_total;
    for (int i = 0; i < 400; i++) begin
      bus.if_ready = ($urandom_range(0, 9) < 7);
      bus.enable   = ($urandom_range(0, 19) != 0);
      if (exp_issue >= 32'h300 || $urandom_range(0, 29) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'($urandom_range(0, 127)) << 2;
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    check("random_liveness", (n_total - cnt > 100) ? 32'd1 : 32'd0, 32'd1);

    // Misaligned redirect traps and stays quiet.
    bus.enable         = 1'b1;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("mis_fault", 32'(s_fault), 32'd1);
    check("mis_fault_pc", s_fault_pc, 32'h42);
    n_quiet_req   = 0;
    n_quiet_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_req) n_quiet_req++;
      if (s_valid) n_quiet_valid++;
    end
    check("mis_quiet_req", 32'(n_quiet_req), 32'd0);
    check("mis_quiet_valid", 32'(n_quiet_valid), 32'd0);
    check("mis_fault_held", 32'(s_fault), 32'd1);

    // Run off the end of memory: last word delivered, then trap at 0x400.
    apply_reset();
    bus.enable   = 1'b1;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3C0;
    tick();
    bus.redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (s_fault) found = 1'b1;
    end
    check("end_fault_seen", 32'(found), 32'd1);
    check("end_fault_pc", s_fault_pc, 32'h400);
    check("end_last_pc", last_pc, 32'h3FC);
    check("end_valid", 32'(s_valid), 32'd0);

    // Asynchronous reset mid-run with the FIFO full.
    apply_reset();
    bus.enable   = 1'b1;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.if_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_buffered", 32'(n_issued - n_delivered), 32'd2);
    #2;
    btn_reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1;
    btn_reset = 1'b0;
    sb_reset();
    bus.if_ready = 1'b1;
    cnt = n_total;
    for (int i = 0; i < 12; i++) tick();
    check("restart_delivers", (n_total - cnt > 5) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
